// File: rtl/cdb_arbiter.sv
// cdb_arbiter: buffers completed results from NUM_FU functional units in
// small per-unit FIFOs and broadcasts up to two of them per cycle on the
// common data bus, round-robin across units, program order within a unit.
//
// Ports:
//   clock, reset (async, active-low), flush_in (sync mispredict flush)
//   fu_valid_in / fu_ready_out       per-unit result handshake
//   fu_*_in                          per-unit payload, unit i at slice i
//   cdb1_*_out / cdb2_*_out          registered broadcast channels;
//                                    idle = tag 8'hFF, other fields 0
module cdb_arbiter #(
    parameter int NUM_FU       = 4,
    parameter int DEPTH        = 2,
    parameter int HISTORY_BITS = 8
) (
    input  logic                           clock,
    input  logic                           reset,
    input  logic                           flush_in,
    input  logic [NUM_FU-1:0]              fu_valid_in,
    output logic [NUM_FU-1:0]              fu_ready_out,
    input  logic [8*NUM_FU-1:0]            fu_tag_in,
    input  logic [64*NUM_FU-1:0]           fu_value_in,
    input  logic [NUM_FU-1:0]              fu_mispredicted_in,
    input  logic [2*NUM_FU-1:0]            fu_branch_result_in,
    input  logic [64*NUM_FU-1:0]           fu_NPC_in,
    input  logic [HISTORY_BITS*NUM_FU-1:0] fu_pht_index_in,
    output logic [7:0]                     cdb1_tag_out,
    output logic [63:0]                    cdb1_value_out,
    output logic                           cdb1_mispredicted_out,
    output logic [1:0]                     cdb1_branch_result_out,
    output logic [63:0]                    cdb1_NPC_out,
    output logic [HISTORY_BITS-1:0]        cdb1_pht_index_out,
    output logic [7:0]                     cdb2_tag_out,
    output logic [63:0]                    cdb2_value_out,
    output logic                           cdb2_mispredicted_out,
    output logic [1:0]                     cdb2_branch_result_out,
    output logic [63:0]                    cdb2_NPC_out,
    output logic [HISTORY_BITS-1:0]        cdb2_pht_index_out
);

    localparam int IW = $clog2(NUM_FU);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    typedef struct packed {
        logic [7:0]              tag;
        logic [63:0]             value;
        logic                    mis;
        logic [1:0]              br;
        logic [63:0]             npc;
        logic [HISTORY_BITS-1:0] pht;
    } entry_t;

    function automatic entry_t idle_entry();
        entry_t e;
        e     = '0;
        e.tag = 8'hFF;
        return e;
    endfunction

    function automatic logic [PW-1:0] bump(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    function automatic logic [IW-1:0] next_fu(input logic [IW-1:0] g);
        return (g == IW'(NUM_FU - 1)) ? '0 : g + IW'(1);
    endfunction

    entry_t        mem    [NUM_FU][DEPTH];
    logic [PW-1:0] rd_ptr [NUM_FU];
    logic [PW-1:0] wr_ptr [NUM_FU];
    logic [CW-1:0] count  [NUM_FU];
    logic [IW-1:0] rr_ptr;

    entry_t            in_entry [NUM_FU];
    logic [NUM_FU-1:0] nonempty;
    logic [NUM_FU-1:0] push;
    logic [NUM_FU-1:0] pop;

    logic          g1_valid;
    logic          g2_valid;
    logic [IW-1:0] g1;
    logic [IW-1:0] g2;
    logic [IW:0]   scan;
    entry_t        head1;
    entry_t        head2;
    entry_t        cdb1_q;
    entry_t        cdb2_q;

    always_comb begin
        for (int i = 0; i < NUM_FU; i++) begin
            in_entry[i].tag   = fu_tag_in[8*i +: 8];
            in_entry[i].value = fu_value_in[64*i +: 64];
            in_entry[i].mis   = fu_mispredicted_in[i];
            in_entry[i].br    = fu_branch_result_in[2*i +: 2];
            in_entry[i].npc   = fu_NPC_in[64*i +: 64];
            in_entry[i].pht   = fu_pht_index_in[HISTORY_BITS*i +: HISTORY_BITS];
        end
    end

    // Ready looks only at the registered count: a slot freed by this
    // cycle's dequeue is not offered until the next cycle.
    always_comb begin
        fu_ready_out = '0;
        nonempty     = '0;
        push         = '0;
        for (int i = 0; i < NUM_FU; i++) begin
            fu_ready_out[i] = reset & ~flush_in & (count[i] < CW'(DEPTH));
            nonempty[i]     = (count[i] != '0);
            push[i]         = fu_valid_in[i] & fu_ready_out[i];
        end
    end

    // Scan all units starting at rr_ptr; the first two non-empty units
    // found become g1 and g2, so the two grants always differ.
    always_comb begin
        g1_valid = 1'b0;
        g2_valid = 1'b0;
        g1       = '0;
        g2       = '0;
        scan     = '0;
        for (int i = 0; i < NUM_FU; i++) begin
            scan = {1'b0, rr_ptr} + (IW+1)'(i);
            if (scan >= (IW+1)'(NUM_FU)) begin
                scan = scan - (IW+1)'(NUM_FU);
            end
            if (nonempty[scan[IW-1:0]]) begin
                if (!g1_valid) begin
                    g1_valid = 1'b1;
                    g1       = scan[IW-1:0];
                end else if (!g2_valid) begin
                    g2_valid = 1'b1;
                    g2       = scan[IW-1:0];
                end
            end
        end
    end

    always_comb begin
        pop = '0;
        for (int i = 0; i < NUM_FU; i++) begin
            pop[i] = (g1_valid && g1 == IW'(i)) ||
                     (g2_valid && g2 == IW'(i));
        end
    end

    assign head1 = mem[g1][rd_ptr[g1]];
    assign head2 = mem[g2][rd_ptr[g2]];

    // Storage needs no reset: counts alone decide what is valid.
    always_ff @(posedge clock) begin
        for (int i = 0; i < NUM_FU; i++) begin
            if (push[i]) begin
                mem[i][wr_ptr[i]] <= in_entry[i];
            end
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < NUM_FU; i++) begin
                count[i]  <= '0;
                rd_ptr[i] <= '0;
                wr_ptr[i] <= '0;
            end
            rr_ptr <= '0;
            cdb1_q <= idle_entry();
            cdb2_q <= idle_entry();
        end else if (flush_in) begin
            for (int i = 0; i < NUM_FU; i++) begin
                count[i]  <= '0;
                rd_ptr[i] <= '0;
                wr_ptr[i] <= '0;
            end
            rr_ptr <= '0;
            cdb1_q <= idle_entry();
            cdb2_q <= idle_entry();
        end else begin
            for (int i = 0; i < NUM_FU; i++) begin
                if (push[i]) begin
                    wr_ptr[i] <= bump(wr_ptr[i]);
                end
                if (pop[i]) begin
                    rd_ptr[i] <= bump(rd_ptr[i]);
                end
                if (push[i] && !pop[i]) begin
                    count[i] <= count[i] + CW'(1);
                end else if (!push[i] && pop[i]) begin
                    count[i] <= count[i] - CW'(1);
                end
            end
            cdb1_q <= g1_valid ? head1 : idle_entry();
            cdb2_q <= g2_valid ? head2 : idle_entry();
            if (g2_valid) begin
                rr_ptr <= next_fu(g2);
            end else if (g1_valid) begin
                rr_ptr <= next_fu(g1);
            end
        end
    end

    assign cdb1_tag_out           = cdb1_q.tag;
    assign cdb1_value_out         = cdb1_q.value;
    assign cdb1_mispredicted_out  = cdb1_q.mis;
    assign cdb1_branch_result_out = cdb1_q.br;
    assign cdb1_NPC_out           = cdb1_q.npc;
    assign cdb1_pht_index_out     = cdb1_q.pht;
    assign cdb2_tag_out           = cdb2_q.tag;
    assign cdb2_value_out         = cdb2_q.value;
    assign cdb2_mispredicted_out  = cdb2_q.mis;
    assign cdb2_branch_result_out = cdb2_q.br;
    assign cdb2_NPC_out           = cdb2_q.npc;
    assign cdb2_pht_index_out     = cdb2_q.pht;

endmodule
